// File: rtl/tmds_pkg.sv
// Shared constants for the TMDS encoder: control tokens, disparity width, pipeline latency.
// Latency follows TMDS_OUT_REG_EN (2 without it, 3 with it).
package tmds_pkg;

  localparam int unsigned DISP_W = 5;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

`ifdef TMDS_OUT_REG_EN
  localparam int unsigned LATENCY = 3;
`else
  localparam int unsigned LATENCY = 2;
`endif

  // Map {c1,c0} to its blanking token.
  function automatic logic [9:0] ctrl_token(input logic [1:0] ctrl);
    logic [9:0] tok;
    case (ctrl)
      2'b00:   tok = CTRL_TOKEN_00;
      2'b01:   tok = CTRL_TOKEN_01;
      2'b10:   tok = CTRL_TOKEN_10;
      default: tok = CTRL_TOKEN_11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tm_choice.sv
// Stage-1 transition minimisation: picks XOR or XNOR chaining and flags the choice in q_m[8].
module tm_choice (
  input  logic [7:0] data,
  output logic [8:0] q_m
);

  logic [3:0] n1;
  logic       use_xnor;
  logic [7:0] chain;

  always_comb begin
    n1 = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1 = n1 + 4'(data[i]);
    end
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !data[0]);
    chain    = 8'd0;
    chain[0] = data[0];
    for (int i = 1; i < 8; i++) begin
      chain[i] = use_xnor ? ~(chain[i-1] ^ data[i]) : (chain[i-1] ^ data[i]);
    end
    q_m = {~use_xnor, chain};
  end

endmodule

// File: rtl/tmds_encoder.sv
// Per-channel 8b/10b TMDS encoder: stage 1 transition minimisation, stage 2 DC balance.
// Define TMDS_OUT_REG_EN to add an output register (latency 3 instead of 2).
module tmds_encoder
  import tmds_pkg::*;
(
  input  logic       pixel_clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic [1:0] control_in,
  input  logic       ve_in,
  output logic [9:0] tmds_out
);

  logic [8:0] q_m_c;
  logic [8:0] q_m_r;
  logic       ve_r;
  logic [1:0] ctrl_r;

  tm_choice u_tm_choice (
    .data (data_in),
    .q_m  (q_m_c)
  );

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      q_m_r  <= 9'd0;
      ve_r   <= 1'b0;
      ctrl_r <= 2'b00;
    end else begin
      q_m_r  <= q_m_c;
      ve_r   <= ve_in;
      ctrl_r <= control_in;
    end
  end

  logic        [3:0]        n1_c;
  logic signed [DISP_W-1:0] diff_c;
  logic signed [DISP_W-1:0] q8x2_c;
  logic signed [DISP_W-1:0] nq8x2_c;
  logic signed [DISP_W-1:0] cnt;
  logic signed [DISP_W-1:0] cnt_next_c;
  logic        [9:0]        sym_c;
  logic        [9:0]        sym_r;
  logic                     cnt_pos_c;
  logic                     diff_pos_c;

  // diff_c is N1-N0 = 2*N1-8, kept in the 5-bit disparity domain.
  always_comb begin
    n1_c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1_c = n1_c + 4'(q_m_r[i]);
    end
    diff_c     = $signed({n1_c, 1'b0}) - 5'sd8;
    q8x2_c     = q_m_r[8] ? 5'sd2 : 5'sd0;
    nq8x2_c    = q_m_r[8] ? 5'sd0 : 5'sd2;
    cnt_pos_c  = !cnt[DISP_W-1] && (cnt != 5'sd0);
    diff_pos_c = !diff_c[DISP_W-1] && (diff_c != 5'sd0);

    sym_c      = 10'd0;
    cnt_next_c = cnt;
    if (!ve_r) begin
      sym_c      = ctrl_token(ctrl_r);
      cnt_next_c = 5'sd0;
    end else if ((cnt == 5'sd0) || (diff_c == 5'sd0)) begin
      sym_c      = {~q_m_r[8], q_m_r[8], q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0]};
      cnt_next_c = q_m_r[8] ? (cnt + diff_c) : (cnt - diff_c);
    end else if ((cnt_pos_c && diff_pos_c) || (cnt[DISP_W-1] && diff_c[DISP_W-1])) begin
      sym_c      = {1'b1, q_m_r[8], ~q_m_r[7:0]};
      cnt_next_c = cnt + q8x2_c - diff_c;
    end else begin
      sym_c      = {1'b0, q_m_r[8], q_m_r[7:0]};
      cnt_next_c = cnt + diff_c - nq8x2_c;
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      sym_r <= 10'd0;
      cnt   <= 5'sd0;
    end else begin
      sym_r <= sym_c;
      cnt   <= cnt_next_c;
    end
  end

`ifdef TMDS_OUT_REG_EN
  logic [9:0] out_r;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      out_r <= 10'd0;
    end else begin
      out_r <= sym_r;
    end
  end

  assign tmds_out = out_r;
`else
  assign tmds_out = sym_r;
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed and random-burst bench for tmds_encoder; expected symbols are hand-computed,
// random pixels are checked by independent decode and stream disparity.
module tb_tmds_encoder;

`ifdef TMDS_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int MAXS = 2048;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  // Modes: 0 ignore, 1 blank token (clears disparity), 3 exact data symbol, 2 random pixel
  localparam int M_NONE = 0;
  localparam int M_BLANK = 1;
  localparam int M_RAND = 2;
  localparam int M_DATA = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ve = 1'b0;
  logic [1:0] ctrl = 2'b00;
  logic [7:0] data = 8'h00;
  logic [9:0] tmds;

  always #5 clk = ~clk;

  tmds_encoder dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .data_in      (data),
    .control_in   (ctrl),
    .ve_in        (ve),
    .tmds_out     (tmds)
  );

  int         total = 0;
  int         bad = 0;
  int         step = 0;
  int         acc = 0;
  bit         rst_prev = 1'b1;
  logic [9:0] exp_arr [MAXS];
  int         mode_arr [MAXS];
  logic [7:0] byte_arr [MAXS];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", tag, step, act, exp);
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] sym);
    logic [7:0] d;
    logic [7:0] o;
    d = sym[9] ? ~sym[7:0] : sym[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

  function automatic int ones(input logic [9:0] sym);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      n += int'(sym[i]);
    end
    return n;
  endfunction

  // One pixel clock: observe the symbol due now, then drive the next inputs.
  task automatic tick(input bit r, input bit v, input logic [1:0] c, input logic [7:0] d,
                      input int mode, input logic [9:0] e);
    int k;
    @(posedge clk);
    #1;
    if (rst_prev) begin
      check("reset_zero", 32'(tmds), 32'(0));
    end else if (step >= LAT) begin
      k = step - LAT;
      case (mode_arr[k])
        M_BLANK: begin
          check("ctrl_token", 32'(tmds), 32'(exp_arr[k]));
          acc = 0;
        end
        M_DATA: begin
          check("data_sym", 32'(tmds), 32'(exp_arr[k]));
        end
        M_RAND: begin
          check("decode", 32'(decode(tmds)), 32'(byte_arr[k]));
          acc += 2 * ones(tmds) - 10;
          check("disparity_bound", 32'((acc > 10) || (acc < -10)), 32'(0));
        end
        default: ;
      endcase
    end
    rst  = r;
    ve   = v;
    ctrl = v ? 2'($urandom) : c;
    data = v ? d : 8'($urandom);
    mode_arr[step] = mode;
    exp_arr[step]  = e;
    byte_arr[step] = d;
    rst_prev = r;
    step++;
  endtask

  task automatic blank(input int n);
    repeat (n) tick(1'b0, 1'b0, 2'b00, 8'h00, M_BLANK, T00);
  endtask

  initial begin
    repeat (3) tick(1'b1, 1'b0, 2'b00, 8'h00, M_NONE, 10'd0);
    blank(3);
    tick(1'b0, 1'b0, 2'b01, 8'h00, M_BLANK, T01);
    tick(1'b0, 1'b0, 2'b10, 8'h00, M_BLANK, T10);
    tick(1'b0, 1'b0, 2'b11, 8'h00, M_BLANK, T11);
    blank(2);
    // 0x00 run from cnt=0: cnt -8, 2, -6, 4
    tick(1'b0, 1'b1, 2'b00, 8'h00, M_DATA, 10'b0100000000);
    tick(1'b0, 1'b1, 2'b00, 8'h00, M_DATA, 10'b1111111111);
    tick(1'b0, 1'b1, 2'b00, 8'h00, M_DATA, 10'b0100000000);
    tick(1'b0, 1'b1, 2'b00, 8'h00, M_DATA, 10'b1111111111);
    blank(1);
    tick(1'b0, 1'b1, 2'b00, 8'hFF, M_DATA, 10'b1000000000);
    blank(1);
    // Single blank must clear cnt=-8 so the second 0x00 is not inverted
    tick(1'b0, 1'b1, 2'b00, 8'h00, M_DATA, 10'b0100000000);
    blank(1);
    tick(1'b0, 1'b1, 2'b00, 8'h00, M_DATA, 10'b0100000000);
    blank(2);
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < 50; i++) begin
        tick(1'b0, 1'b1, 2'b00, 8'($urandom), M_RAND, 10'd0);
      end
      blank(2);
    end
    blank(LAT + 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
